// File: rtl/mux_sel_ctrl_if.sv
// Pin-side bundle for mux_sel_ctrl: raw control/operand inputs in,
// registered mux operands, select and debug state out.
interface mux_sel_ctrl_if;
  logic       ena;
  logic       btn;
  logic       mode_auto;
  logic       force_en;
  logic       force_val;
  logic       a_raw;
  logic       b_raw;
  logic       a;
  logic       b;
  logic       sl;
  logic       sel_pulse;
  logic [1:0] dbg_state;

  modport master (
    output ena, btn, mode_auto, force_en, force_val, a_raw, b_raw,
    input  a, b, sl, sel_pulse, dbg_state
  );

  modport slave (
    input  ena, btn, mode_auto, force_en, force_val, a_raw, b_raw,
    output a, b, sl, sel_pulse, dbg_state
  );
endinterface

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: select/operand control stage for a 2:1 mux cell.
// Synchronises raw pins, debounces a toggle button, supports periodic
// auto-toggle and a force override; a, b and sl are registered together.
// Optional build macro MUX_SEL_BLANK_EN: blank a/b to 0 on the edge
// where sl changes (one-cycle switchover blanking).
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 256,
  parameter int CNT_W           = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_sel_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } dbn_state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);

  logic [1:0]       rst_pipe;
  logic             run;
  logic [5:0]       raw, s1, s2;
  logic             btn_s, mode_auto_s, force_en_s, force_val_s, a_raw_s, b_raw_s;
  dbn_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, acnt, acnt_n;
  logic             press_evt, auto_run, auto_evt;
  logic             sl_q, sl_n, sl_chg, pulse_q, a_q, b_q, a_n, b_n;

  // Reset asserts asynchronously; release is held off two edges so the
  // first functional edge is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign run = bus.ena & ~rst_pipe[1];

  assign raw = {bus.btn, bus.mode_auto, bus.force_en, bus.force_val, bus.a_raw, bus.b_raw};
  assign {btn_s, mode_auto_s, force_en_s, force_val_s, a_raw_s, b_raw_s} = s2;

  // Two-flop synchronisers for every raw pin, frozen by ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else if (run) begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce next-state: a press/release is accepted only after
  // DEBOUNCE_CYCLES consecutive stable samples.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) state_n = IDLE;
        else if (cnt == DEB_LAST) begin
          state_n   = HELD;
          press_evt = 1'b1;
        end else cnt_n = cnt + CNT_W'(1);
      end
      HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) state_n = HELD;
        else if (cnt == DEB_LAST) state_n = IDLE;
        else cnt_n = cnt + CNT_W'(1);
      end
    endcase
  end

  // Auto counter and select arbitration: force beats auto beats button.
  // In auto mode the FSM still tracks the button but its event is dropped.
  always_comb begin
    auto_run = mode_auto_s & ~force_en_s;
    auto_evt = auto_run && (acnt == AUTO_LAST);
    acnt_n   = (!auto_run || auto_evt) ? '0 : acnt + CNT_W'(1);
    if (force_en_s)       sl_n = force_val_s;
    else if (mode_auto_s) sl_n = sl_q ^ auto_evt;
    else                  sl_n = sl_q ^ press_evt;
    sl_chg = sl_n ^ sl_q;
`ifdef MUX_SEL_BLANK_EN
    a_n = a_raw_s & ~sl_chg;
    b_n = b_raw_s & ~sl_chg;
`else
    a_n = a_raw_s;
    b_n = b_raw_s;
`endif
  end

  // State, counters and registered mux operands/select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acnt    <= '0;
      sl_q    <= 1'b0;
      pulse_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else if (run) begin
      state   <= state_n;
      cnt     <= cnt_n;
      acnt    <= acnt_n;
      sl_q    <= sl_n;
      pulse_q <= sl_chg;
      a_q     <= a_n;
      b_q     <= b_n;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.sl        = sl_q;
  assign bus.sel_pulse = pulse_q & bus.ena;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
// Edge numbering: an input set before edge 1 is first sampled there.
module tb_mux_sel_ctrl;
  localparam int DEB = 4;
  localparam int PER = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef MUX_SEL_BLANK_EN
  localparam logic BLANK_AB = 1'b0;
`else
  localparam logic BLANK_AB = 1'b1;
`endif

  mux_sel_ctrl_if bus();

  mux_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(PER), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.btn = 1'b0; bus.mode_auto = 1'b0; bus.force_en = 1'b0;
    bus.force_val = 1'b0; bus.a_raw = 1'b0; bus.b_raw = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got a,b,sl,pulse,dbg=%b expected 000000",
               {bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state});
    end
    tick(2);
    rst = 1'b0;
    tick(4);
    checks++;
    if ({bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_release got %b expected 000000",
               {bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state});
    end
  endtask

  task automatic test_press();
    int pc;
    pc = 0;
    bus.btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      pc += int'(bus.sel_pulse);
      if (e == 3) begin
        checks++;
        if (bus.dbg_state !== 2'b01) begin failures++; $display("FAIL press_pwait got %b expected 01", bus.dbg_state); end
      end
      if (e == 6) begin
        checks++;
        if (bus.sl !== 1'b0) begin failures++; $display("FAIL press_early got sl=%b expected 0", bus.sl); end
      end
      if (e == 7) begin
        checks++;
        if ({bus.sl, bus.sel_pulse, bus.dbg_state} !== 4'b1110) begin
          failures++; $display("FAIL press_toggle got sl,pulse,dbg=%b expected 1110", {bus.sl, bus.sel_pulse, bus.dbg_state});
        end
      end
      if (e == 8) begin
        checks++;
        if (bus.sel_pulse !== 1'b0) begin failures++; $display("FAIL press_pulse_len got %b expected 0", bus.sel_pulse); end
      end
    end
    bus.btn = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      pc += int'(bus.sel_pulse);
      if (e == 3 || e == 6) begin
        checks++;
        if (bus.dbg_state !== 2'b11) begin failures++; $display("FAIL release_wait e=%0d got %b expected 11", e, bus.dbg_state); end
      end
      if (e == 7) begin
        checks++;
        if (bus.dbg_state !== 2'b00) begin failures++; $display("FAIL release_idle got %b expected 00", bus.dbg_state); end
      end
    end
    checks++;
    if (pc !== 1 || bus.sl !== 1'b1) begin
      failures++; $display("FAIL press_count got pulses=%0d sl=%b expected 1/1", pc, bus.sl);
    end
    bus.btn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 7) begin
        checks++;
        if ({bus.sl, bus.sel_pulse} !== 2'b01) begin failures++; $display("FAIL press2 got sl,pulse=%b expected 01", {bus.sl, bus.sel_pulse}); end
      end
    end
    bus.btn = 1'b0;
    tick(10);
  endtask

  task automatic test_bounce();
    int pc;
    logic seen_held;
    pc = 0; seen_held = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      bus.btn = (e <= 3) || (e >= 5 && e <= 7);
      tick(1);
      pc += int'(bus.sel_pulse);
      if (bus.dbg_state[1]) seen_held = 1'b1;
      if (e == 5) begin
        checks++;
        if (bus.dbg_state !== 2'b01) begin failures++; $display("FAIL bounce_pwait got %b expected 01", bus.dbg_state); end
      end
      if (e == 6) begin
        checks++;
        if (bus.dbg_state !== 2'b00) begin failures++; $display("FAIL bounce_abort got %b expected 00", bus.dbg_state); end
      end
    end
    checks++;
    if (pc !== 0 || bus.sl !== 1'b0 || seen_held !== 1'b0 || bus.dbg_state !== 2'b00) begin
      failures++; $display("FAIL bounce_reject got pulses=%0d sl=%b held=%b dbg=%b expected 0/0/0/00", pc, bus.sl, seen_held, bus.dbg_state);
    end
  endtask

  task automatic test_auto();
    int pc;
    pc = 0;
    bus.mode_auto = 1'b1;
    for (int e = 1; e <= 52; e++) begin
      if (e == 41) bus.mode_auto = 1'b0;
      bus.btn = (e >= 14 && e < 24);
      tick(1);
      pc += int'(bus.sel_pulse);
      if (e == 9) begin
        checks++;
        if (bus.sl !== 1'b0) begin failures++; $display("FAIL auto_early got sl=%b expected 0", bus.sl); end
      end
      if (e == 10) begin
        checks++;
        if ({bus.sl, bus.sel_pulse} !== 2'b11) begin failures++; $display("FAIL auto_first got sl,pulse=%b expected 11", {bus.sl, bus.sel_pulse}); end
      end
      if (e == 18) begin
        checks++;
        if (bus.sl !== 1'b0) begin failures++; $display("FAIL auto_second got sl=%b expected 0", bus.sl); end
      end
    end
    checks++;
    if (pc !== 5 || bus.sl !== 1'b1 || bus.dbg_state !== 2'b00) begin
      failures++; $display("FAIL auto_count got pulses=%0d sl=%b dbg=%b expected 5/1/00", pc, bus.sl, bus.dbg_state);
    end
  endtask

  task automatic test_force();
    int pc;
    bus.mode_auto = 1'b1; bus.force_en = 1'b1; bus.force_val = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      if (e == 2) begin
        checks++;
        if (bus.sl !== 1'b1) begin failures++; $display("FAIL force0_early got sl=%b expected 1", bus.sl); end
      end
      if (e == 3) begin
        checks++;
        if ({bus.sl, bus.sel_pulse} !== 2'b01) begin failures++; $display("FAIL force0 got sl,pulse=%b expected 01", {bus.sl, bus.sel_pulse}); end
      end
    end
    bus.force_val = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      if (e == 2) begin
        checks++;
        if (bus.sl !== 1'b0) begin failures++; $display("FAIL force1_early got sl=%b expected 0", bus.sl); end
      end
      if (e == 3) begin
        checks++;
        if (bus.sl !== 1'b1) begin failures++; $display("FAIL force1 got sl=%b expected 1", bus.sl); end
      end
    end
    pc = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      pc += int'(bus.sel_pulse);
    end
    checks++;
    if (pc !== 0 || bus.sl !== 1'b1) begin failures++; $display("FAIL force_hold got pulses=%0d sl=%b expected 0/1", pc, bus.sl); end
    bus.force_en = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 9) begin
        checks++;
        if (bus.sl !== 1'b1) begin failures++; $display("FAIL force_rel_early got sl=%b expected 1", bus.sl); end
      end
      if (e == 10) begin
        checks++;
        if ({bus.sl, bus.sel_pulse} !== 2'b01) begin failures++; $display("FAIL force_rel_toggle got sl,pulse=%b expected 01", {bus.sl, bus.sel_pulse}); end
      end
    end
    bus.mode_auto = 1'b0; bus.force_val = 1'b0;
    tick(6);
    checks++;
    if (bus.sl !== 1'b0) begin failures++; $display("FAIL force_end got sl=%b expected 0", bus.sl); end
  endtask

  task automatic test_ena();
    bus.a_raw = 1'b1; bus.b_raw = 1'b0;
    tick(3);
    checks++;
    if ({bus.a, bus.b} !== 2'b10) begin failures++; $display("FAIL ena_operands got a,b=%b expected 10", {bus.a, bus.b}); end
    bus.btn = 1'b1;
    tick(6);
    bus.ena = 1'b0; bus.a_raw = 1'b0; bus.b_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      checks++;
      if ({bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state} !== 6'b100001) begin
        failures++; $display("FAIL ena_freeze e=%0d got a,b,sl,pulse,dbg=%b expected 100001", e, {bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state});
      end
    end
    bus.ena = 1'b1;
    tick(1);
    checks++;
    if ({bus.sl, bus.sel_pulse} !== 2'b11) begin failures++; $display("FAIL ena_resume got sl,pulse=%b expected 11", {bus.sl, bus.sel_pulse}); end
    bus.ena = 1'b0;
    #1;
    checks++;
    if (bus.sel_pulse !== 1'b0) begin failures++; $display("FAIL ena_pulse_mask got %b expected 0", bus.sel_pulse); end
    bus.ena = 1'b1;
    bus.btn = 1'b0; bus.a_raw = 1'b0; bus.b_raw = 1'b0;
    tick(12);
    checks++;
    if ({bus.a, bus.sl, bus.dbg_state} !== 4'b0100) begin failures++; $display("FAIL ena_end got a,sl,dbg=%b expected 0100", {bus.a, bus.sl, bus.dbg_state}); end
  endtask

  task automatic test_reset_mid();
    int pc;
    bus.a_raw = 1'b1; bus.b_raw = 1'b1; bus.btn = 1'b1;
    tick(4);
    checks++;
    if ({bus.a, bus.b, bus.sl, bus.dbg_state} !== 5'b11101) begin
      failures++; $display("FAIL rstmid_pre got a,b,sl,dbg=%b expected 11101", {bus.a, bus.b, bus.sl, bus.dbg_state});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state} !== 6'b0) begin
      failures++; $display("FAIL rstmid_async got %b expected 000000", {bus.a, bus.b, bus.sl, bus.sel_pulse, bus.dbg_state});
    end
    bus.btn = 1'b0; bus.a_raw = 1'b0; bus.b_raw = 1'b0;
    tick(2);
    rst = 1'b0;
    pc = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      pc += int'(bus.sel_pulse);
    end
    checks++;
    if (pc !== 0 || bus.sl !== 1'b0 || bus.dbg_state !== 2'b00) begin
      failures++; $display("FAIL rstmid_after got pulses=%0d sl=%b dbg=%b expected 0/0/00", pc, bus.sl, bus.dbg_state);
    end
  endtask

  task automatic test_blank();
    bus.a_raw = 1'b1; bus.b_raw = 1'b1;
    tick(3);
    bus.btn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (e == 6 || e == 8) begin
        checks++;
        if ({bus.a, bus.b} !== 2'b11) begin failures++; $display("FAIL blank_track e=%0d got a,b=%b expected 11", e, {bus.a, bus.b}); end
      end
      if (e == 7) begin
        checks++;
        if ({bus.sl, bus.a, bus.b} !== {1'b1, BLANK_AB, BLANK_AB}) begin
          failures++; $display("FAIL blank_switch got sl,a,b=%b expected %b", {bus.sl, bus.a, bus.b}, {1'b1, BLANK_AB, BLANK_AB});
        end
      end
    end
    bus.btn = 1'b0;
    tick(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_auto();
    test_force();
    test_ena();
    test_reset_mid();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Control stage directly upstream of the 2:1 mux cell; produces that cell's `a`, `b` and `sl` inputs.
- Synchronises raw pin inputs and debounces a select push-button; each clean press toggles `sl`.
- Also supports an auto-toggle mode (fixed period) and a force override.
- Outputs are registered, so the downstream mux sees glitch-free, clock-aligned operands and select.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (>=2)
AUTO_PERIOD, 256, cycles between sl toggles in auto mode (>=2)
CNT_W, 8, counter width; must satisfy 2^CNT_W >= max(DEBOUNCE_CYCLES, AUTO_PERIOD)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset (codebase clock/reset naming; polarity and synchronicity fixed)
ena  input  1  clock enable; 0 freezes all state
btn  input  1  raw asynchronous select-toggle button
mode_auto  input  1  raw; 1 = periodic auto-toggle
force_en  input  1  raw; 1 = sl forced to force_val
force_val  input  1  raw forced select value
a_raw  input  1  raw operand A
b_raw  input  1  raw operand B
a  output  1  registered operand A to mux
b  output  1  registered operand B to mux
sl  output  1  registered select to mux
sel_pulse  output  1  one-cycle pulse on any sl change
dbg_state  output  2  debounce FSM state encoding

Behaviour:
- Reset (async assert, sync-released by the design): all sync flops 0; FSM IDLE; counters 0; a=b=sl=sel_pulse=0; dbg_state=00.
- Synchronisation:
  - Every raw input passes through 2 flops; `*_s` denotes the synchronised value.
  - A raw change is visible in `*_s` after 2 enabled edges.
- Debounce FSM (dbg_state encoding):
  - IDLE (00):
    - btn_s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT (01):
    - btn_s=0 -> IDLE.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HELD and raise press_evt; else cnt++.
  - HELD (10):
    - btn_s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT (11):
    - btn_s=1 -> HELD.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
- Press latency: with btn held, sl toggles on edge DEBOUNCE_CYCLES+3 counted from the first edge that samples btn=1.
- A bounce shorter than DEBOUNCE_CYCLES produces no toggle.
- Auto counter:
  - Runs only while mode_auto_s=1 and force_en_s=0.
  - When acnt==AUTO_PERIOD-1: acnt=0 and raise auto_evt; else acnt++.
  - Cleared to 0 whenever mode_auto_s=0 or force_en_s=1.
- sl update priority, evaluated per enabled edge:
  1. force_en_s=1 -> sl=force_val_s.
  2. mode_auto_s=1 -> toggle on auto_evt; press_evt is ignored, but the FSM keeps tracking.
  3. Otherwise -> toggle on press_evt.
- sel_pulse = 1 for exactly the cycle after any edge where sl changed value. A force write of an equal value gives no pulse.
- Operands: a<=a_raw_s, b<=b_raw_s each enabled edge, so a/b/sl share identical latency.
- ena=0:
  - No flop updates, including synchronisers; outputs hold.
  - sel_pulse is forced 0 while ena=0.
- Reset mid-debounce or mid-period aborts immediately. No toggle is emitted after release of reset.

Optional Feature:
- Macro MUX_SEL_BLANK_EN.
- Defined: on the edge where sl changes, a and b are forced to 0 for that cycle only (1-cycle blanking), then resume tracking. Downstream mux output is 0 during the switchover.
- Undefined: a/b never blanked; behaviour exactly as above.

Test Plan:
- Bench configuration: DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
- Reset check: assert rst mid-run with sl=1 -> a=b=sl=sel_pulse=0 and dbg_state=00 immediately, with no clock required.
- Clean press: btn 0->1 held 20 cycles, then released -> sl 0->1 on edge 7 after the rising sample; sel_pulse high 1 cycle; dbg_state 00->01->10->11->00. Second press -> sl=0.
- Bounce reject: btn high 3 cycles, low 1, high 3, low -> sl unchanged, no sel_pulse, FSM returns to IDLE.
- Auto mode: mode_auto=1 for 40 cycles -> sl toggles every 8 cycles (5 toggles). A button press during this window causes no extra toggle.
- Force and ena:
  - force_en=1, force_val=1 with auto active -> sl=1 after 3 edges; auto counter held at 0.
  - ena=0 for 10 cycles -> all outputs frozen and sel_pulse=0.
- Blanking (MUX_SEL_BLANK_EN defined): a_raw=b_raw=1, trigger a toggle -> a=b=0 in the sl-change cycle, 1 on the next.
